fragment_writer: RTL and testbench

Write-side counterpart to the scan-out display path. Accepts rasterized fragments (x, y, depth, colour) over a valid/ready stream and performs a read-modify-write depth test against the depth buffer. Writes colour and depth into the framebuffer and depth buffer through their shared write port. Also owns full-buffer clears, sweeping every address with the clear values between frames.

---
 rtl/fragment_writer_pkg.sv | 26 ++
 rtl/fragment_writer_if.sv | 15 +
 rtl/fragment_writer_depth_forward.sv | 39 +++
 rtl/fragment_writer.sv | 215 +++++++++++++++++++++
 tb/tb_fragment_writer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fragment_writer_pkg.sv
// fragment_pkg: shared types and constants for the fragment writer.
//   fragment_t     : one rasterized fragment (signed x/y, depth, palette colour)
//   state_t        : writer control state (RUN / DRAIN / CLEAR)
//   DB_CLEAR_VALUE : depth written on clear (farthest possible depth)
package fragment_pkg;

  localparam int COORD_W = 16;
  localparam int DEPTH_W = 12;
  localparam int COLOR_W = 4;

  localparam logic [DEPTH_W-1:0] DB_CLEAR_VALUE = '1;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic [DEPTH_W-1:0]        depth;
    logic [COLOR_W-1:0]        color;
  } fragment_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/fragment_writer_if.sv
// fragment_writer_if: valid/ready fragment stream into the fragment writer.
//   frag_valid : fragment present (master -> slave)
//   frag       : fragment payload (master -> slave)
//   frag_ready : fragment accepted when valid && ready (slave -> master)
interface fragment_writer_if;
  import fragment_pkg::*;

  logic      frag_valid;
  logic      frag_ready;
  fragment_t frag;

  modport master (output frag_valid, output frag, input frag_ready);
  modport slave  (input frag_valid, input frag, output frag_ready);

endinterface

// File: rtl/fragment_writer_depth_forward.sv
// depth_forward: resolves the depth currently stored at lookup_addr.
// The memory read is stale when a write to the same address is still in
// flight, so the two most recent writes are checked first.
//   lookup_addr     : address whose stored depth is wanted
//   p2_*            : write being presented to the buffers this cycle
//   p3_*            : last write already handed to the buffers
//   mem_depth       : synchronous read data from the depth buffer
//   stored_depth    : effective stored depth (p2 > p3 > memory)
//   hit_p2, hit_p3  : which history entry supplied the depth
module depth_forward #(
  parameter int AW = 15,
  parameter int DW = 12
) (
  input  logic [AW-1:0] lookup_addr,
  input  logic          p2_valid,
  input  logic [AW-1:0] p2_addr,
  input  logic [DW-1:0] p2_depth,
  input  logic          p3_valid,
  input  logic [AW-1:0] p3_addr,
  input  logic [DW-1:0] p3_depth,
  input  logic [DW-1:0] mem_depth,
  output logic [DW-1:0] stored_depth,
  output logic          hit_p2,
  output logic          hit_p3
);

  assign hit_p2 = p2_valid && (p2_addr == lookup_addr);
  assign hit_p3 = p3_valid && (p3_addr == lookup_addr);

  always_comb begin
    stored_depth = mem_depth;
    if (hit_p2) begin
      stored_depth = p2_depth;
    end else if (hit_p3) begin
      stored_depth = p3_depth;
    end
  end

endmodule

// File: rtl/fragment_writer.sv
// fragment_writer: depth-tested fragment writes into the framebuffer and
// depth buffer, plus full-buffer clears.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   RUN   | accepting fragments (unless a clear is pending)
//   DRAIN | clear pending, waiting for P1/P2 to empty
//   CLEAR | sweeping every address with the clear values
//
// Ports:
//   clk, rstn          : clock, async active-low reset
//   clear_req          : one-cycle clear request pulse
//   fin                : fragment stream (valid/ready/payload)
//   db_addr_read       : depth-buffer read address (1-cycle read latency)
//   db_data_read       : depth-buffer read data
//   buffer_addr_write  : shared write address for both buffers
//   o_fb_data          : framebuffer write data
//   o_db_data          : depth-buffer write data
//   write_enable       : write strobe for both buffers
//   busy               : clear in progress or pipeline non-empty
//   clear_done         : one-cycle pulse at the end of a clear sweep
module fragment_writer
  import fragment_pkg::*;
#(
  parameter int DISPLAY_WIDTH       = 160,
  parameter int DISPLAY_HEIGHT      = 120,
  parameter int DISPLAY_COORD_WIDTH = COORD_W,
  parameter int FB_DATA_WIDTH       = COLOR_W,
  parameter int DB_DATA_WIDTH       = DEPTH_W,
  parameter int CLEAR_COLOR         = 0,
  localparam int BUFFER_ADDR_WIDTH  = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clear_req,
  fragment_writer_if.slave             fin,
  output logic [BUFFER_ADDR_WIDTH-1:0] db_addr_read,
  input  logic [DB_DATA_WIDTH-1:0]     db_data_read,
  output logic [BUFFER_ADDR_WIDTH-1:0] buffer_addr_write,
  output logic [FB_DATA_WIDTH-1:0]     o_fb_data,
  output logic [DB_DATA_WIDTH-1:0]     o_db_data,
  output logic                         write_enable,
  output logic                         busy,
  output logic                         clear_done
);

  localparam int AW   = BUFFER_ADDR_WIDTH;
  localparam int CW   = DISPLAY_COORD_WIDTH;
  localparam int NPIX = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  state_t state_q, state_d;
  logic          pending_q;
  logic [AW-1:0] clr_cnt_q;
  logic          sweep_last;
  logic          accept;

  logic signed [CW-1:0] fx, fy;
  logic [AW:0]          addr_full;
  logic                 in_range;

  logic                     p1_valid_q, p1_in_range_q;
  logic [AW-1:0]            p1_addr_q;
  logic [DB_DATA_WIDTH-1:0] p1_depth_q;
  logic [FB_DATA_WIDTH-1:0] p1_color_q;

  logic                     p2_valid_q, p2_in_range_q;
  logic [AW-1:0]            p2_addr_q;
  logic [DB_DATA_WIDTH-1:0] p2_depth_q;
  logic [FB_DATA_WIDTH-1:0] p2_color_q;

  // out_frag_q marks the registered write as a fragment write, so clear
  // writes never enter the forwarding history.
  logic                     out_frag_q;
  logic                     p3_valid_q;
  logic [AW-1:0]            p3_addr_q;
  logic [DB_DATA_WIDTH-1:0] p3_depth_q;

  logic                     we_d, frag_d;
  logic [AW-1:0]            addr_d;
  logic [FB_DATA_WIDTH-1:0] fb_d;
  logic [DB_DATA_WIDTH-1:0] db_d;

  logic [DB_DATA_WIDTH-1:0] stored_depth;
  logic                     hit_p2, hit_p3;
  // Hit flags are not needed for the write decision; kept for debug probing.
  logic                     fwd_hit_unused;

  assign fin.frag_ready = (state_q == RUN) && !pending_q;
  assign accept         = fin.frag_valid && fin.frag_ready;
  assign sweep_last     = (state_q == CLEAR) && (clr_cnt_q == LAST_ADDR);
  assign busy           = (state_q != RUN) || p1_valid_q || p2_valid_q;
  assign db_addr_read   = p1_addr_q;

  // Address is formed one bit wider than the buffer so an out-of-range
  // coordinate can never alias onto a legal address before the check.
  assign fx        = fin.frag.x;
  assign fy        = fin.frag.y;
  assign addr_full = fy[AW:0] * (AW+1)'(DISPLAY_WIDTH) + fx[AW:0];
  assign in_range  = !fx[CW-1] && !fy[CW-1]
                  && ($unsigned(fx) < CW'(DISPLAY_WIDTH))
                  && ($unsigned(fy) < CW'(DISPLAY_HEIGHT))
                  && (addr_full < (AW+1)'(NPIX));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (pending_q) state_d = DRAIN;
      DRAIN:   if (!p1_valid_q && !p2_valid_q) state_d = CLEAR;
      CLEAR:   if (sweep_last) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  depth_forward #(.AW(AW), .DW(DB_DATA_WIDTH)) u_depth_forward (
    .lookup_addr  (p2_addr_q),
    .p2_valid     (write_enable && out_frag_q),
    .p2_addr      (buffer_addr_write),
    .p2_depth     (o_db_data),
    .p3_valid     (p3_valid_q),
    .p3_addr      (p3_addr_q),
    .p3_depth     (p3_depth_q),
    .mem_depth    (db_data_read),
    .stored_depth (stored_depth),
    .hit_p2       (hit_p2),
    .hit_p3       (hit_p3)
  );

  assign fwd_hit_unused = hit_p2 | hit_p3;

  always_comb begin
    we_d   = 1'b0;
    frag_d = 1'b0;
    addr_d = p2_addr_q;
    fb_d   = p2_color_q;
    db_d   = p2_depth_q;
    if (state_q == CLEAR) begin
      we_d   = 1'b1;
      addr_d = clr_cnt_q;
      fb_d   = FB_DATA_WIDTH'(CLEAR_COLOR);
      db_d   = DB_CLEAR_VALUE;
    end else if (p2_valid_q && p2_in_range_q && (p2_depth_q < stored_depth)) begin
      we_d   = 1'b1;
      frag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= RUN;
      pending_q  <= 1'b0;
      clr_cnt_q  <= '0;
      clear_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      // A request arriving mid-clear folds into the sweep already underway.
      pending_q  <= sweep_last ? 1'b0 : (pending_q | clear_req);
      clr_cnt_q  <= (state_q == CLEAR && !sweep_last) ? clr_cnt_q + 1'b1 : '0;
      clear_done <= sweep_last;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p1_valid_q        <= 1'b0;
      p1_in_range_q     <= 1'b0;
      p1_addr_q         <= '0;
      p1_depth_q        <= '0;
      p1_color_q        <= '0;
      p2_valid_q        <= 1'b0;
      p2_in_range_q     <= 1'b0;
      p2_addr_q         <= '0;
      p2_depth_q        <= '0;
      p2_color_q        <= '0;
      write_enable      <= 1'b0;
      out_frag_q        <= 1'b0;
      buffer_addr_write <= '0;
      o_fb_data         <= '0;
      o_db_data         <= '0;
      p3_valid_q        <= 1'b0;
      p3_addr_q         <= '0;
      p3_depth_q        <= '0;
    end else begin
      p1_valid_q <= accept;
      if (accept) begin
        p1_in_range_q <= in_range;
        p1_addr_q     <= addr_full[AW-1:0];
        p1_depth_q    <= fin.frag.depth;
        p1_color_q    <= fin.frag.color;
      end
      p2_valid_q <= p1_valid_q;
      if (p1_valid_q) begin
        p2_in_range_q <= p1_in_range_q;
        p2_addr_q     <= p1_addr_q;
        p2_depth_q    <= p1_depth_q;
        p2_color_q    <= p1_color_q;
      end
      write_enable      <= we_d;
      out_frag_q        <= frag_d;
      buffer_addr_write <= addr_d;
      o_fb_data         <= fb_d;
      o_db_data         <= db_d;
      // P3 covers the read-first window: the write committing this edge is
      // not yet visible to a read issued on the same edge.
      if (sweep_last) begin
        p3_valid_q <= 1'b0;
      end else if (write_enable && out_frag_q) begin
        p3_valid_q <= 1'b1;
        p3_addr_q  <= buffer_addr_write;
        p3_depth_q <= o_db_data;
      end
    end
  end

endmodule

// File: tb/tb_fragment_writer.sv
module tb_fragment_writer;
  import fragment_pkg::*;

  typedef struct packed {
    logic [14:0] addr;
    logic [3:0]  fb;
    logic [11:0] db;
  } wr_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clear_req;
  logic [14:0] db_addr_read;
  logic [11:0] db_data_read;
  logic [14:0] buffer_addr_write;
  logic [3:0]  o_fb_data;
  logic [11:0] o_db_data;
  logic        write_enable;
  logic        busy;
  logic        clear_done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [11:0] dbmem [0:19199];
  wr_t         wlog[$];

  fragment_writer_if fif();

  fragment_writer dut (
    .clk               (clk),
    .rstn              (rstn),
    .clear_req         (clear_req),
    .fin               (fif),
    .db_addr_read      (db_addr_read),
    .db_data_read      (db_data_read),
    .buffer_addr_write (buffer_addr_write),
    .o_fb_data         (o_fb_data),
    .o_db_data         (o_db_data),
    .write_enable      (write_enable),
    .busy              (busy),
    .clear_done        (clear_done)
  );

  always #5 clk = ~clk;

  // Read-first synchronous depth buffer.
  always @(posedge clk) begin
    db_data_read <= (db_addr_read < 15'd19200) ? dbmem[db_addr_read] : 12'h000;
    if (write_enable) dbmem[buffer_addr_write] <= o_db_data;
  end

  always @(posedge clk) begin
    if (write_enable) wlog.push_back('{buffer_addr_write, o_fb_data, o_db_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_frag(input int x, input int y, input int d, input int c);
    fif.frag_valid   = 1'b1;
    fif.frag.x       = 16'(x);
    fif.frag.y       = 16'(y);
    fif.frag.depth   = 12'(d);
    fif.frag.color   = 4'(c);
  endtask

  // Waits for a clear sweep already requested; extra = fragment writes
  // expected to drain inside the window.
  task automatic wait_clear(input string tag, input int extra);
    int nwe, nclr, bad, ndone, done_cyc, busy_bad;
    logic rdy_at_done;
    nwe = 0; nclr = 0; bad = 0; ndone = 0; done_cyc = 0; busy_bad = 0;
    rdy_at_done = 1'b0;
    for (int cyc = 1; cyc <= 19300 && ndone == 0; cyc++) begin
      tick();
      if (write_enable) begin
        nwe++;
        if (o_fb_data == 4'h0 && o_db_data == 12'hFFF) begin
          if (buffer_addr_write != 15'(nclr)) bad++;
          nclr++;
        end
      end
      if (clear_done) begin
        ndone++;
        done_cyc    = cyc;
        rdy_at_done = fif.frag_ready;
      end else if (!busy) begin
        busy_bad++;
      end
    end
    repeat (3) begin
      tick();
      if (clear_done) ndone++;
    end
    check({tag, "_we_cycles"}, nwe, 19200 + extra);
    check({tag, "_clear_writes"}, nclr, 19200);
    check({tag, "_addr_seq_errs"}, bad, 0);
    check({tag, "_done_pulses"}, ndone, 1);
    check({tag, "_latency_ok"}, (done_cyc > 0 && done_cyc <= 19203), 1);
    check({tag, "_busy_gaps"}, busy_bad, 0);
    check({tag, "_ready_after"}, rdy_at_done, 1);
  endtask

  initial begin
    rstn           = 1'b0;
    clear_req      = 1'b0;
    fif.frag_valid = 1'b0;
    fif.frag       = '0;
    repeat (3) tick();

    check("rst_we", write_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_db_addr_read", db_addr_read, 0);
    check("rst_addr_write", buffer_addr_write, 0);
    check("rst_fb_data", o_fb_data, 0);
    check("rst_db_data", o_db_data, 0);
    rstn = 1'b1;
    tick();
    check("rst_ready", fif.frag_ready, 1);

    // Full clear from reset.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_clear("clr1", 0);
    tick();

    // Single fragment against a cleared pixel: write two edges after accept.
    put_frag(5, 2, 12'h100, 3);
    check("single_ready", fif.frag_ready, 1);
    tick();
    fif.frag_valid = 1'b0;
    check("single_rd_addr", db_addr_read, 325);
    check("single_busy", busy, 1);
    check("single_we_n0", write_enable, 0);
    tick();
    check("single_we_n1", write_enable, 0);
    tick();
    check("single_we_n2", write_enable, 1);
    check("single_addr", buffer_addr_write, 325);
    check("single_fb", o_fb_data, 3);
    check("single_db", o_db_data, 12'h100);
    tick();
    check("single_we_n3", write_enable, 0);
    repeat (3) tick();

    // Equal and farther depth both lose against stored 0x100.
    wlog.delete();
    put_frag(5, 2, 12'h100, 7);
    tick();
    put_frag(5, 2, 12'h200, 7);
    tick();
    fif.frag_valid = 1'b0;
    repeat (6) tick();
    check("reject_writes", wlog.size(), 0);

    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_clear("clr2", 0);
    tick();

    // Back-to-back same-address hazard.
    wlog.delete();
    put_frag(5, 2, 12'h300, 1);
    check("hz_ready0", fif.frag_ready, 1);
    tick();
    put_frag(5, 2, 12'h200, 2);
    check("hz_ready1", fif.frag_ready, 1);
    tick();
    put_frag(5, 2, 12'h250, 3);
    check("hz_ready2", fif.frag_ready, 1);
    tick();
    put_frag(5, 2, 12'h100, 4);
    check("hz_ready3", fif.frag_ready, 1);
    tick();
    fif.frag_valid = 1'b0;
    repeat (6) tick();
    check("hz_count", wlog.size(), 3);
    check("hz_w0_addr", wlog[0].addr, 325);
    check("hz_w0_fb", wlog[0].fb, 1);
    check("hz_w0_db", wlog[0].db, 12'h300);
    check("hz_w1_fb", wlog[1].fb, 2);
    check("hz_w1_db", wlog[1].db, 12'h200);
    check("hz_w2_addr", wlog[2].addr, 325);
    check("hz_w2_fb", wlog[2].fb, 4);
    check("hz_w2_db", wlog[2].db, 12'h100);

    // Out-of-range drops, then the last legal pixel.
    wlog.delete();
    put_frag(-1, 0, 12'h001, 9);
    check("rng_ready_xneg", fif.frag_ready, 1);
    tick();
    put_frag(160, 0, 12'h001, 9);
    check("rng_ready_xhi", fif.frag_ready, 1);
    tick();
    put_frag(0, 120, 12'h001, 9);
    check("rng_ready_yhi", fif.frag_ready, 1);
    tick();
    put_frag(159, 119, 12'h010, 9);
    check("rng_ready_corner", fif.frag_ready, 1);
    tick();
    fif.frag_valid = 1'b0;
    repeat (6) tick();
    check("rng_count", wlog.size(), 1);
    check("rng_corner_addr", wlog[0].addr, 19199);
    check("rng_corner_fb", wlog[0].fb, 9);
    check("rng_corner_db", wlog[0].db, 12'h010);

    // Clear requested while P1 and P2 both hold fragments.
    wlog.delete();
    put_frag(10, 0, 12'h050, 5);
    tick();
    put_frag(11, 0, 12'h060, 6);
    tick();
    fif.frag_valid = 1'b0;
    clear_req      = 1'b1;
    tick();
    clear_req = 1'b0;
    check("cds_ready_drop", fif.frag_ready, 0);
    check("cds_busy", busy, 1);
    wait_clear("clr3", 1);
    check("cds_log_size", wlog.size(), 19202);
    check("cds_w0_addr", wlog[0].addr, 10);
    check("cds_w0_data", {wlog[0].fb, wlog[0].db}, {4'h5, 12'h050});
    check("cds_w1_addr", wlog[1].addr, 11);
    check("cds_w1_data", {wlog[1].fb, wlog[1].db}, {4'h6, 12'h060});
    check("cds_w2_addr", wlog[2].addr, 0);
    check("cds_w2_db", wlog[2].db, 12'hFFF);
    check("cds_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
